// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory store port and its write buffer.
package mem_pkg;

    localparam int unsigned WORD_OFS = 2;
    localparam int unsigned IDX_W    = 32 - WORD_OFS;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } wb_entry_t;

    // Word index with the address aliased into the array depth.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr,
                                                  input int unsigned mem_words);
        return IDX_W'((addr >> WORD_OFS) & (mem_words - 32'd1));
    endfunction

endpackage

// File: rtl/dmem_store_port_if.sv
// Store-commit, load-request/response and status signals of the data-memory port.
interface dmem_store_port_if #(
    parameter int unsigned PR_BITS = 6
);
    logic               st_en;
    logic [31:0]        st_addr;
    logic [31:0]        st_data;
    logic               ld_req_valid;
    logic               ld_req_ready;
    logic [31:0]        ld_addr;
    logic [PR_BITS-1:0] ld_rd_phys;
    logic               ld_resp_valid;
    logic [31:0]        ld_resp_data;
    logic [PR_BITS-1:0] ld_resp_rd_phys;
    logic               wb_empty;
    logic               wb_full;
    logic               misalign_err;

    modport master (
        output st_en, st_addr, st_data, ld_req_valid, ld_addr, ld_rd_phys,
        input  ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_rd_phys,
               wb_empty, wb_full, misalign_err
    );

    modport slave (
        input  st_en, st_addr, st_data, ld_req_valid, ld_addr, ld_rd_phys,
        output ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_rd_phys,
               wb_empty, wb_full, misalign_err
    );
endinterface

// File: rtl/dmem_store_port_wb.sv
// In-order store write buffer with a parallel youngest-match forwarding search.
module dmem_wb
    import mem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned AW       = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [IDX_W-1:0]          push_idx,
    input  logic [31:0]               push_data,
    input  logic                      pop,
    input  logic [IDX_W-1:0]          lookup_idx,
    output logic                      hit,
    output logic [31:0]               fwd_data,
    output logic [AW-1:0]             head_idx,
    output logic [31:0]               head_data,
    output logic [$clog2(WB_DEPTH):0] count,
    output logic                      empty,
    output logic                      full
);
    localparam int unsigned PTR_W = $clog2(WB_DEPTH);

    wb_entry_t        entries_q [WB_DEPTH];
    wb_entry_t        entries_d [WB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] slot;

    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (entries_q[slot].valid && entries_q[slot].idx == lookup_idx) begin
                hit      = 1'b1;
                fwd_data = entries_q[slot].data;
            end
        end
    end

    // Push is applied after pop so a full-buffer push into the freed head slot wins.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (push) begin
            entries_d[tail_q] = '{valid: 1'b1, idx: push_idx, data: push_data};
            tail_d            = tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign head_idx  = entries_q[head_q].idx[AW-1:0];
    assign head_data = entries_q[head_q].data;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(WB_DEPTH));

endmodule

// File: rtl/dmem_store_port.sv
// Data-memory responder: buffers committed stores, drains them to a single-port
// array and answers loads in one cycle with store-to-load forwarding.
module dmem_store_port
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned WB_DEPTH  = 4,
    parameter int unsigned PR_BITS   = 6
) (
    input logic               clk,
    input logic               rst_n,
    dmem_store_port_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]               mem_q [MEM_WORDS];

    logic                      st_misalign, ld_misalign;
    logic                      st_push, ld_ready, ld_accept, pop;
    logic [IDX_W-1:0]          st_idx, ld_idx;
    logic                      wb_hit;
    logic [31:0]               fwd_data, head_data;
    logic [AW-1:0]             head_idx;
    logic [$clog2(WB_DEPTH):0] wb_count;
    logic                      wb_empty_s, wb_full_s;

    logic                      resp_valid_q, resp_valid_d;
    logic [31:0]               resp_data_q, resp_data_d;
    logic [PR_BITS-1:0]        resp_tag_q, resp_tag_d;
    logic                      err_q, err_d;

    dmem_wb #(
        .WB_DEPTH (WB_DEPTH),
        .AW       (AW)
    ) u_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (st_push),
        .push_idx   (st_idx),
        .push_data  (bus.st_data),
        .pop        (pop),
        .lookup_idx (ld_idx),
        .hit        (wb_hit),
        .fwd_data   (fwd_data),
        .head_idx   (head_idx),
        .head_data  (head_data),
        .count      (wb_count),
        .empty      (wb_empty_s),
        .full       (wb_full_s)
    );

    // A full buffer takes the array port, so any same-cycle push always finds room.
    always_comb begin
        st_idx      = word_idx(bus.st_addr, MEM_WORDS);
        ld_idx      = word_idx(bus.ld_addr, MEM_WORDS);
        st_misalign = bus.st_en && (bus.st_addr[1:0] != 2'b00);
        ld_misalign = bus.ld_addr[1:0] != 2'b00;
        st_push     = bus.st_en && !st_misalign;
        ld_ready    = !wb_full_s;
        ld_accept   = bus.ld_req_valid && ld_ready;
        pop         = (wb_count != '0) && !ld_accept;

        resp_valid_d = ld_accept;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        if (ld_accept) begin
            resp_tag_d = bus.ld_rd_phys;
            if (ld_misalign) begin
                resp_data_d = '0;
            end else if (wb_hit) begin
                resp_data_d = fwd_data;
            end else begin
                resp_data_d = mem_q[ld_idx[AW-1:0]];
            end
        end
        err_d = err_q || st_misalign || (ld_accept && ld_misalign);
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            mem_q[head_idx] <= head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
            err_q        <= err_d;
        end
    end

    assign bus.ld_req_ready    = ld_ready;
    assign bus.ld_resp_valid   = resp_valid_q;
    assign bus.ld_resp_data    = resp_data_q;
    assign bus.ld_resp_rd_phys = resp_tag_q;
    assign bus.wb_empty        = wb_empty_s;
    assign bus.wb_full         = wb_full_s;
    assign bus.misalign_err    = err_q;

endmodule
